// File: rtl/turn_blink_ctrl.sv
// Turn-signal / hazard blink controller sharing one blink timebase.
// Optional turn auto-cancel (HOLD state, blink counter) enabled by TURN_AUTO_CANCEL_EN.
module turn_blink_ctrl #(
  parameter int unsigned HALF_PERIOD = 25_000_000,
  parameter int unsigned MAX_BLINKS  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       left_req,
  input  logic       right_req,
  input  logic       hazard_req,
  output logic       led_left,
  output logic       led_right,
  output logic       phase_tick,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEFT   = 3'd1,
    RIGHT  = 3'd2,
    HAZARD = 3'd3,
    HOLD   = 3'd4
  } state_t;

  localparam logic [31:0] HP_M1 = 32'(HALF_PERIOD - 1);

  state_t      state_q, state_d, req;
  logic [31:0] cnt_q, cnt_d;
  logic        phase_q, phase_d;
  logic        tick_q, tick_d;
  logic        led_left_q, led_left_d;
  logic        led_right_q, led_right_d;
  logic        blinking;

`ifdef TURN_AUTO_CANCEL_EN
  localparam logic [7:0] MAX_B = 8'(MAX_BLINKS);
  logic [7:0] blink_q, blink_d;
  logic       hold_left_q, hold_left_d;
`endif

  always_comb begin
    if (!en)                       req = IDLE;
    else if (hazard_req)           req = HAZARD;
    else if (left_req && right_req) req = IDLE;
    else if (left_req)             req = LEFT;
    else if (right_req)            req = RIGHT;
    else                           req = IDLE;
  end

  always_comb begin
    state_d = req;
    cnt_d   = '0;
    phase_d = 1'b0;
    tick_d  = 1'b0;
`ifdef TURN_AUTO_CANCEL_EN
    blink_d     = blink_q;
    hold_left_d = hold_left_q;
    // HOLD persists only while the lever that caused the cancel is still the request
    if (state_q == HOLD &&
        ((req == LEFT && hold_left_q) || (req == RIGHT && !hold_left_q)))
      state_d = HOLD;
`endif
    blinking = (state_d == LEFT) || (state_d == RIGHT) || (state_d == HAZARD);

    if (state_d != state_q) begin
      if (blinking) begin
        phase_d = 1'b1;
      end
`ifdef TURN_AUTO_CANCEL_EN
      blink_d = '0;
`endif
    end else if (blinking) begin
      if (cnt_q == HP_M1) begin
        phase_d = ~phase_q;
        tick_d  = 1'b1;
`ifdef TURN_AUTO_CANCEL_EN
        if (state_q != HAZARD && phase_q) begin
          blink_d = blink_q + 8'd1;
          if (blink_d == MAX_B) begin
            state_d     = HOLD;
            phase_d     = 1'b0;
            hold_left_d = (state_q == LEFT);
          end
        end
`endif
      end else begin
        cnt_d   = cnt_q + 32'd1;
        phase_d = phase_q;
      end
    end

    led_left_d  = phase_d && (state_d == LEFT  || state_d == HAZARD);
    led_right_d = phase_d && (state_d == RIGHT || state_d == HAZARD);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      phase_q     <= 1'b0;
      tick_q      <= 1'b0;
      led_left_q  <= 1'b0;
      led_right_q <= 1'b0;
`ifdef TURN_AUTO_CANCEL_EN
      blink_q     <= '0;
      hold_left_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      tick_q      <= tick_d;
      led_left_q  <= led_left_d;
      led_right_q <= led_right_d;
`ifdef TURN_AUTO_CANCEL_EN
      blink_q     <= blink_d;
      hold_left_q <= hold_left_d;
`endif
    end
  end

  assign led_left   = led_left_q;
  assign led_right  = led_right_q;
  assign phase_tick = tick_q;
  assign state      = state_q;

endmodule

// File: tb/tb_turn_blink_ctrl.sv
// Directed self-checking bench for turn_blink_ctrl with HALF_PERIOD=4, MAX_BLINKS=2.
module tb_turn_blink_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, left_req, right_req, hazard_req;
  logic       led_left, led_right, phase_tick;
  logic [2:0] state;

  int unsigned errors = 0;
  int unsigned checks = 0;

  turn_blink_ctrl #(.HALF_PERIOD(4), .MAX_BLINKS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .left_req   (left_req),
    .right_req  (right_req),
    .hazard_req (hazard_req),
    .led_left   (led_left),
    .led_right  (led_right),
    .phase_tick (phase_tick),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] st, input logic ll,
                           input logic lr, input logic pt);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".led_left"}, 32'(led_left), 32'(ll));
    check({tag, ".led_right"}, 32'(led_right), 32'(lr));
    check({tag, ".phase_tick"}, 32'(phase_tick), 32'(pt));
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; left_req = 1'b0; right_req = 1'b0; hazard_req = 1'b0;
    tick(); tick();
    check_all("reset", 3'd0, 1'b0, 1'b0, 1'b0);

    // Left blink: on for edges 0..3, off 4..7, on again at 8; ticks at 4 and 8.
    rst = 1'b1; en = 1'b1; left_req = 1'b1;
    tick();
    check_all("left_e0", 3'd1, 1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 10; e++) begin
      tick();
      check_all($sformatf("left_e%0d", e), 3'd1, ((e / 4) % 2) == 0, 1'b0, (e % 4) == 0);
    end

    // Hazard mid-phase (cnt=2), four cycles both on, then back to fresh LEFT.
    hazard_req = 1'b1;
    tick();
    check_all("haz_h0", 3'd3, 1'b1, 1'b1, 1'b0);
    for (int h = 1; h <= 3; h++) begin
      tick();
      check_all($sformatf("haz_h%0d", h), 3'd3, 1'b1, 1'b1, 1'b0);
    end
    hazard_req = 1'b0;
    tick();
    check_all("haz_back_l0", 3'd1, 1'b1, 1'b0, 1'b0);
    for (int h = 1; h <= 4; h++) begin
      tick();
      check_all($sformatf("haz_back_l%0d", h), 3'd1, h < 4, 1'b0, h == 4);
    end

    // Direct LEFT->RIGHT switch restarts with a full on-phase.
    left_req = 1'b0; right_req = 1'b1;
    tick();
    check_all("l2r_0", 3'd2, 1'b0, 1'b1, 1'b0);

    // Conflicting levers -> IDLE; en low overrides hazard.
    left_req = 1'b1;
    tick();
    check_all("conflict", 3'd0, 1'b0, 1'b0, 1'b0);
    en = 1'b0; hazard_req = 1'b1; left_req = 1'b0; right_req = 1'b0;
    tick();
    check_all("en_low", 3'd0, 1'b0, 1'b0, 1'b0);

    // Reset mid-blink, then re-entry with a full on-phase.
    en = 1'b1; hazard_req = 1'b0; right_req = 1'b1;
    tick();
    check_all("right_r0", 3'd2, 1'b0, 1'b1, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check_all("mid_reset", 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    check_all("post_reset_0", 3'd2, 1'b0, 1'b1, 1'b0);
    for (int e = 1; e <= 4; e++) begin
      tick();
      check_all($sformatf("post_reset_%0d", e), 3'd2, 1'b0, e < 4, e == 4);
    end

    // Release latency.
    right_req = 1'b0;
    tick();
    check_all("release", 3'd0, 1'b0, 1'b0, 1'b0);

    right_req = 1'b1;
    tick();
    check_all("cancel_r0", 3'd2, 1'b0, 1'b1, 1'b0);
`ifdef TURN_AUTO_CANCEL_EN
    for (int e = 1; e <= 11; e++) begin
      tick();
      check_all($sformatf("cancel_r%0d", e), 3'd2, 1'b0, ((e / 4) % 2) == 0, (e % 4) == 0);
    end
    tick();
    check_all("cancel_hold", 3'd4, 1'b0, 1'b0, 1'b1);
    tick();
    check_all("cancel_hold2", 3'd4, 1'b0, 1'b0, 1'b0);
    right_req = 1'b0;
    tick();
    check_all("hold_release", 3'd0, 1'b0, 1'b0, 1'b0);
`else
    for (int e = 1; e <= 100; e++) begin
      tick();
      check_all($sformatf("long_r%0d", e), 3'd2, 1'b0, ((e / 4) % 2) == 0, (e % 4) == 0);
    end
    right_req = 1'b0;
    tick();
    check_all("long_release", 3'd0, 1'b0, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
